path_arbiter: RTL



---
 rtl/path_arbiter_if.sv | 30 +++
 rtl/path_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/path_arbiter_if.sv
// Handshake bundle between the path bank, the arbiter and the consumer.
// Arbiter side is the slave modport; the environment drives the master.
interface path_arbiter_if #(
  parameter int DWIDTH = 8,
  parameter int NPORTS = 4
);
  localparam int IDW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic                     enable_i;
  logic [NPORTS-1:0]        req_i;
  logic [NPORTS*DWIDTH-1:0] data_i;
  logic [NPORTS-1:0]        gnt_o;
  logic                     ready_i;
  logic                     valid_o;
  logic [DWIDTH-1:0]        data_o;
  logic [IDW-1:0]           grant_id_o;
  logic                     busy_o;

  modport slave (
    input  enable_i, req_i, data_i, ready_i,
    output gnt_o, valid_o, data_o,
    output grant_id_o, busy_o
  );

  modport master (
    output enable_i, req_i, data_i, ready_i,
    input  gnt_o, valid_o, data_o,
    input  grant_id_o, busy_o
  );
endinterface

// File: rtl/path_arbiter.sv
// Round-robin arbiter with bounded bursts and a registered
// valid/ready output stage fed by the winning path.
module path_arbiter #(
  parameter int DWIDTH = 8,
  parameter int NPORTS = 4,
  parameter int BURST  = 4
) (
  input logic           clk,
  input logic           rst,
  path_arbiter_if.slave bus
);
  localparam int IDW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW  = $clog2(BURST + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    owner;
  logic [CW-1:0]     cnt;
  logic              valid;
  logic [DWIDTH-1:0] data;
  logic [IDW-1:0]    grant_id;

  logic              can_issue;
  logic              found;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    gidx;
  logic [NPORTS-1:0] gnt;
  logic [DWIDTH-1:0] wdata;

  function automatic logic [IDW-1:0] inc(
    input logic [IDW-1:0] p
  );
    return (p == IDW'(NPORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign can_issue = bus.enable_i &&
                     (!valid || bus.ready_i);

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!found &&
          bus.req_i[(int'(rr_ptr) + i) % NPORTS]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr) + i) % NPORTS);
      end
    end
  end

  always_comb begin
    gnt  = '0;
    gidx = owner;
    unique case (1'b1)
      !rst && state == IDLE &&
      can_issue && found: begin
        gnt[win] = 1'b1;
        gidx     = win;
      end
      !rst && state == LOCK &&
      bus.req_i[owner] && can_issue: begin
        gnt[owner] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wdata = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (gnt[k]) wdata = bus.data_i[k*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      valid    <= 1'b0;
      data     <= '0;
      grant_id <= '0;
    end else begin
      if (|gnt) begin
        valid    <= 1'b1;
        data     <= wdata;
        grant_id <= gidx;
      end else if (bus.ready_i) begin
        valid    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner <= win;
            cnt   <= CW'(1);
            if (BURST == 1) rr_ptr <= inc(win);
            else            state  <= LOCK;
          end
        end
        LOCK: begin
          // owner dropping its request costs one idle cycle
          if (!bus.req_i[owner]) begin
            state  <= IDLE;
            rr_ptr <= inc(owner);
          end else if (can_issue) begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == CW'(BURST)) begin
              state  <= IDLE;
              rr_ptr <= inc(owner);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.valid_o    = valid;
  assign bus.data_o     = data;
  assign bus.grant_id_o = grant_id;
  assign bus.busy_o     = (state == LOCK);
endmodule
